// File: rtl/ide_pio_if.sv
// Bus bundle between the 68000 side, the IDE pins and the PIO sequencer.
interface ide_pio_if;
  // 68000 side and IDE pin inputs
  logic        _AS;
  logic        R_W;
  logic        _UDS;
  logic        _LDS;
  logic        ide_sel;
  logic        cs_bank;
  logic [2:0]  reg_a;
  logic        IORDY;
  logic [15:0] DD;
  // Sequencer outputs
  logic [2:0]  DA;
  logic [1:0]  _CS;
  logic        _DIOR;
  logic        _DIOW;
  logic        dd_oe;
  logic        d_oe;
  logic [15:0] rd_data;
  logic        ide_dtack;
  logic        busy;
  logic        tmo_flag;

  modport slave (
    input  _AS, R_W, _UDS, _LDS, ide_sel, cs_bank, reg_a, IORDY, DD,
    output DA, _CS, _DIOR, _DIOW, dd_oe, d_oe, rd_data, ide_dtack, busy, tmo_flag
  );

  modport master (
    output _AS, R_W, _UDS, _LDS, ide_sel, cs_bank, reg_a, IORDY, DD,
    input  DA, _CS, _DIOR, _DIOW, dd_oe, d_oe, rd_data, ide_dtack, busy, tmo_flag
  );
endinterface

// File: rtl/ide_pio_sequencer.sv
// One ATA PIO access per 68000 bus cycle: counted setup/strobe/recovery with
// IORDY stretching and a sticky timeout flag. All outputs are registered.
module ide_pio_sequencer #(
  parameter int unsigned T_SETUP   = 1,
  parameter int unsigned T_STROBE  = 3,
  parameter int unsigned T_RECOVER = 1,
  parameter int unsigned TMO_MAX   = 31,
  parameter int unsigned CNT_W     = 5
) (
  input  logic      CLK,
  input  logic      _RESET,
  ide_pio_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StAck, StRecover} state_e;

  localparam logic [CNT_W-1:0] CntSetup   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] CntStrobe  = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] CntRecover = CNT_W'(T_RECOVER - 1);
  localparam logic [CNT_W-1:0] TmoMax     = CNT_W'(TMO_MAX);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // phase counter, reloaded on every state entry
  logic [CNT_W-1:0] ext_q, ext_d;     // IORDY extension cycles used so far
  logic             write_q, write_d;
  logic             bank_q, bank_d;
  logic [2:0]       da_q, da_d;
  logic [1:0]       cs_n_q, cs_n_d;
  logic             dior_n_q, dior_n_d;
  logic             diow_n_q, diow_n_d;
  logic             dd_oe_q, dd_oe_d;
  logic             d_oe_q, d_oe_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             dtack_q, dtack_d;
  logic             busy_q, busy_d;
  logic             tmo_q, tmo_d;
  logic             req;
  logic             start;

  assign req = bus.ide_sel & ~bus._AS & (~bus._UDS | ~bus._LDS);

  // Next state, counters, latched request and next registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    write_d   = write_q;
    bank_d    = bank_q;
    da_d      = da_q;
    rd_data_d = rd_data_q;
    tmo_d     = tmo_q;
    start     = 1'b0;

    case (state_q)
      StIdle: start = req;
      StSetup: begin
        if (bus._AS) begin
          state_d = StRecover;
          cnt_d   = CntRecover;
        end else if (cnt_q == '0) begin
          state_d = StStrobe;
          cnt_d   = CntStrobe;
          ext_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StStrobe: begin
        if (bus._AS) begin
          state_d = StRecover;
          cnt_d   = CntRecover;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else if (bus.IORDY || (ext_q == TmoMax)) begin
          // Complete; a timed-out access still completes but is flagged
          state_d = StAck;
          if (!bus.IORDY) tmo_d = 1'b1;
          if (!write_q) rd_data_d = bus.DD;
        end else begin
          ext_d = ext_q + CntOne;
        end
      end
      StAck: begin
        if (bus._AS) begin
          state_d = StRecover;
          cnt_d   = CntRecover;
        end
      end
      StRecover: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else if (req) begin
          start = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d = StSetup;
      cnt_d   = CntSetup;
      write_d = ~bus.R_W;
      bank_d  = bus.cs_bank;
      da_d    = bus.reg_a;
    end

    cs_n_d   = 2'b11;
    dior_n_d = 1'b1;
    diow_n_d = 1'b1;
    dd_oe_d  = 1'b0;
    d_oe_d   = 1'b0;
    dtack_d  = 1'b0;
    busy_d   = (state_d != StIdle);

    case (state_d)
      StSetup: begin
        cs_n_d  = bank_d ? 2'b01 : 2'b10;
        dd_oe_d = write_d;
      end
      StStrobe: begin
        cs_n_d   = bank_d ? 2'b01 : 2'b10;
        dior_n_d = write_d;
        diow_n_d = ~write_d;
        dd_oe_d  = write_d;
      end
      StAck: begin
        cs_n_d  = bank_d ? 2'b01 : 2'b10;
        dtack_d = 1'b1;
        d_oe_d  = ~write_d;
        // Write data held for exactly one cycle past the strobe
        dd_oe_d = write_d & (state_q == StStrobe);
      end
      default: ;
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ext_q     <= '0;
      write_q   <= 1'b0;
      bank_q    <= 1'b0;
      da_q      <= '0;
      cs_n_q    <= 2'b11;
      dior_n_q  <= 1'b1;
      diow_n_q  <= 1'b1;
      dd_oe_q   <= 1'b0;
      d_oe_q    <= 1'b0;
      rd_data_q <= '0;
      dtack_q   <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ext_q     <= ext_d;
      write_q   <= write_d;
      bank_q    <= bank_d;
      da_q      <= da_d;
      cs_n_q    <= cs_n_d;
      dior_n_q  <= dior_n_d;
      diow_n_q  <= diow_n_d;
      dd_oe_q   <= dd_oe_d;
      d_oe_q    <= d_oe_d;
      rd_data_q <= rd_data_d;
      dtack_q   <= dtack_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.DA        = da_q;
  assign bus._CS       = cs_n_q;
  assign bus._DIOR     = dior_n_q;
  assign bus._DIOW     = diow_n_q;
  assign bus.dd_oe     = dd_oe_q;
  assign bus.d_oe      = d_oe_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.ide_dtack = dtack_q;
  assign bus.busy      = busy_q;
  assign bus.tmo_flag  = tmo_q;

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Bench for ide_pio_sequencer: a transaction-level timeline model fills an
// expected-output table per clock edge; one process compares every cycle.
module tb_ide_pio_sequencer;

  localparam int Ts    = 1;
  localparam int Tst   = 3;
  localparam int Tr    = 1;
  localparam int Tmo   = 31;
  localparam int Depth = 1024;

  typedef struct packed {
    logic [2:0]  da;
    logic [1:0]  cs;
    logic        dior;
    logic        diow;
    logic        dd_oe;
    logic        d_oe;
    logic [15:0] rd;
    logic        dtack;
    logic        busy;
    logic        tmo;
  } out_t;

  logic CLK;
  logic rst_n;
  ide_pio_if bus ();

  ide_pio_sequencer #(
    .T_SETUP  (Ts),
    .T_STROBE (Tst),
    .T_RECOVER(Tr),
    .TMO_MAX  (Tmo),
    .CNT_W    (5)
  ) dut (
    .CLK    (CLK),
    ._RESET (rst_n),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  out_t exp_q [Depth];
  bit   exp_v [Depth];

  // Model state carried between transactions
  logic [15:0] m_rd;
  logic [2:0]  m_da;
  logic        m_tmo;
  int          m_free;

  int strobe_cnt, dtack_cnt, ddoe_cnt, first_dt;

  always @(posedge CLK) edge_n++;

  out_t dut_vec;
  assign dut_vec = '{da: bus.DA, cs: bus._CS, dior: bus._DIOR, diow: bus._DIOW,
                     dd_oe: bus.dd_oe, d_oe: bus.d_oe, rd: bus.rd_data,
                     dtack: bus.ide_dtack, busy: bus.busy, tmo: bus.tmo_flag};

  // Compare process: every edge with an expectation is checked mid-cycle
  always @(negedge CLK) begin
    if (edge_n < Depth && exp_v[edge_n]) begin
      n_cmp++;
      if (dut_vec !== exp_q[edge_n]) begin
        n_fail++;
        $display("FAIL outputs@edge%0d got %h want %h", edge_n, dut_vec, exp_q[edge_n]);
      end
    end
  end

  // Activity monitor for the literal pins
  always @(negedge CLK) begin
    if (bus._DIOR === 1'b0 || bus._DIOW === 1'b0) strobe_cnt++;
    if (bus.dd_oe === 1'b1) ddoe_cnt++;
    if (bus.ide_dtack === 1'b1) begin
      dtack_cnt++;
      if (first_dt < 0) first_dt = edge_n;
    end
  end

  function automatic out_t idle_vec();
    out_t o;
    o = '{da: m_da, cs: 2'b11, dior: 1'b1, diow: 1'b1, dd_oe: 1'b0, d_oe: 1'b0,
          rd: m_rd, dtack: 1'b0, busy: 1'b0, tmo: m_tmo};
    return o;
  endfunction

  task automatic set_exp(input int e, input out_t o);
    if (e < Depth) begin
      exp_q[e] = o;
      exp_v[e] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic clr_mon();
    strobe_cnt = 0;
    dtack_cnt  = 0;
    ddoe_cnt   = 0;
    first_dt   = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (edge_n + 1 >= m_free) set_exp(edge_n + 1, idle_vec());
      @(posedge CLK);
      #1;
    end
  endtask

  // One bus cycle. ext: IORDY-low cycles after the counted strobe; abort_at /
  // rst_at: edge offset from request sampling where _AS rises / _RESET falls.
  task automatic txn(input bit rd, input bit bank, input logic [2:0] ra,
                     input logic [15:0] dd, input int ext, input int abort_at,
                     input int hold, input int rst_at, output int e0);
    int   s, x, ex, a;
    bit   aborted, tmo_hit;
    out_t o;
    e0 = edge_n + 1;
    if (e0 < m_free) e0 = m_free;
    s       = e0 + Ts;
    x       = (ext > Tmo) ? Tmo : ext;
    tmo_hit = (ext > Tmo);
    ex      = s + Tst + x;
    aborted = (abort_at > 0) || (rst_at > 0);
    if (rst_at > 0)        a = e0 + rst_at;
    else if (abort_at > 0) a = e0 + abort_at;
    else                   a = ex + hold;

    m_da = ra;
    for (int e = e0; e < ((rst_at > 0) ? a : a + Tr); e++) begin
      if (!aborted && e == ex) begin
        if (rd) m_rd = dd;
        if (tmo_hit) m_tmo = 1'b1;
      end
      o = idle_vec();
      o.busy = 1'b1;
      if (e < a) o.cs = bank ? 2'b01 : 2'b10;
      if (e >= s && e < a && e < ex) begin
        if (rd) o.dior = 1'b0;
        else    o.diow = 1'b0;
      end
      if (!rd && e < a && e <= ex) o.dd_oe = 1'b1;
      if (!aborted && e >= ex && e < a) begin
        o.dtack = 1'b1;
        o.d_oe  = rd;
      end
      set_exp(e, o);
    end
    if (rst_at > 0) begin
      m_rd   = '0;
      m_da   = '0;
      m_tmo  = 1'b0;
      set_exp(a, idle_vec());
      m_free = a + 1;
    end else begin
      m_free = a + Tr;
    end

    for (int e = edge_n + 1; e <= a; e++) begin
      bus.ide_sel = 1'b1;
      bus._UDS    = rd ? 1'b0 : 1'b1;
      bus._LDS    = rd ? 1'b1 : 1'b0;
      // Request fields are scrambled after acceptance to prove they were latched
      bus.R_W     = (e > e0) ? ~rd : rd;
      bus.cs_bank = (e > e0) ? ~bank : bank;
      bus.reg_a   = (e > e0) ? ~ra : ra;
      bus.DD      = dd;
      bus.IORDY   = !(e >= s + Tst && e < s + Tst + ext);
      if (rst_at > 0) begin
        bus._AS = 1'b0;
        rst_n   = (e == a) ? 1'b0 : 1'b1;
      end else begin
        bus._AS = (e < a) ? 1'b0 : 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    rst_n       = 1'b1;
    bus._AS     = 1'b1;
    bus._UDS    = 1'b1;
    bus._LDS    = 1'b1;
    bus.ide_sel = 1'b0;
    bus.IORDY   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int e0, e0b;
    m_rd = '0; m_da = '0; m_tmo = 1'b0; m_free = 0;
    clr_mon();
    rst_n = 1'b0;
    bus._AS = 1'b1; bus.R_W = 1'b1; bus._UDS = 1'b1; bus._LDS = 1'b1;
    bus.ide_sel = 1'b0; bus.cs_bank = 1'b0; bus.reg_a = '0;
    bus.IORDY = 1'b1; bus.DD = '0;
    set_exp(1, idle_vec());
    set_exp(2, idle_vec());
    @(posedge CLK); @(posedge CLK); #1;
    rst_n = 1'b1;
    idle(2);

    // Plain read of the data register
    clr_mon();
    txn(1'b1, 1'b0, 3'd0, 16'hA55A, 0, 0, 2, 0, e0);
    idle(2);
    chk("read_strobe_len", strobe_cnt, 3);
    chk("read_dtack_latency", first_dt - e0, 4);
    chk("read_dtack_len", dtack_cnt, 2);
    chk("read_data", int'(bus.rd_data), 16'hA55A);

    // Write to control block register 6
    clr_mon();
    txn(1'b0, 1'b1, 3'd6, 16'hFFFF, 0, 0, 1, 0, e0);
    idle(1);
    chk("write_strobe_len", strobe_cnt, 3);
    chk("write_ddoe_len", ddoe_cnt, 5);
    chk("write_keeps_rd", int'(bus.rd_data), 16'hA55A);

    // IORDY stretch by five cycles
    clr_mon();
    txn(1'b1, 1'b0, 3'd7, 16'h1234, 5, 0, 1, 0, e0);
    idle(1);
    chk("stretch_strobe_len", strobe_cnt, 8);
    chk("stretch_no_tmo", int'(bus.tmo_flag), 0);
    chk("stretch_data", int'(bus.rd_data), 16'h1234);

    // Back-to-back: second request pending while recovering
    clr_mon();
    txn(1'b1, 1'b1, 3'd3, 16'hBEEF, 0, 0, 1, 0, e0);
    txn(1'b0, 1'b0, 3'd2, 16'h0000, 0, 0, 1, 0, e0b);
    idle(2);
    chk("b2b_start_gap", e0b - e0, 6);
    chk("b2b_strobe_len", strobe_cnt, 6);

    // Abort in STROBE, then abort in SETUP
    clr_mon();
    txn(1'b1, 1'b0, 3'd1, 16'hDEAD, 0, Ts + 2, 1, 0, e0);
    txn(1'b0, 1'b0, 3'd5, 16'h0000, 0, 1, 1, 0, e0);
    idle(2);
    chk("abort_strobe_len", strobe_cnt, 2);
    chk("abort_no_dtack", dtack_cnt, 0);
    chk("abort_rd_kept", int'(bus.rd_data), 16'hBEEF);

    // IORDY stuck low: forced completion with timeout
    clr_mon();
    txn(1'b1, 1'b0, 3'd0, 16'h0F0F, 40, 0, 1, 0, e0);
    idle(1);
    chk("tmo_strobe_len", strobe_cnt, 34);
    chk("tmo_flag_set", int'(bus.tmo_flag), 1);
    chk("tmo_data", int'(bus.rd_data), 16'h0F0F);
    txn(1'b0, 1'b1, 3'd4, 16'h0000, 0, 0, 1, 0, e0);
    idle(1);
    chk("tmo_sticky", int'(bus.tmo_flag), 1);

    // Reset in the middle of a strobe
    txn(1'b1, 1'b0, 3'd3, 16'h5555, 0, 0, 1, Ts + 1, e0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cs", int'(bus._CS), 3);
    chk("rst_rd", int'(bus.rd_data), 0);
    chk("rst_tmo", int'(bus.tmo_flag), 0);
    idle(2);

    txn(1'b1, 1'b0, 3'd1, 16'hC3C3, 0, 0, 1, 0, e0);
    idle(2);
    chk("post_rst_read", int'(bus.rd_data), 16'hC3C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
